// File: rtl/filter_operation_pipe_pkg.sv
// +------------------------------------------------------------------+
// | filter_operation_pipe_pkg: tag constants, filter modes, helpers   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package filter_operation_pipe_pkg;

  localparam int         DEF_TAG_WIDTH    = 2;
  localparam logic [1:0] DEF_INVALID_TAG  = 2'd0;
  localparam logic [1:0] DEF_DATA_TAG0    = 2'd1;
  localparam logic [1:0] DEF_DATA_TAG1    = 2'd2;
  localparam logic [1:0] DEF_DATA_END_TAG = 2'd3;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_BOX  = 2'd1,
    MODE_EDGE = 2'd2,
    MODE_THR  = 2'd3
  } mode_e;

  // round(2^shift / ope^2), e.g. 7282 for a 3x3 window at 16 bits
  function automatic int unsigned box_recip(input int unsigned ope, input int unsigned shift);
    int unsigned n;
    n = ope * ope;
    return ((32'd1 << shift) + n / 2) / n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/filter_operation_pipe_abs_diff.sv
// +------------------------------------------------------------------+
// | abs_diff: registered |a-b| with one cycle of latency              |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module abs_diff #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      y <= '0;
    end else begin
      y <= (a >= b) ? (a - b) : (b - a);
    end
  end

endmodule

`default_nettype wire

// File: rtl/filter_operation_pipe.sv
// +------------------------------------------------------------------+
// | filter_operation_pipe: 3-stage tagged window filter, 4 modes      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module filter_operation_pipe
  import filter_operation_pipe_pkg::*;
#(
  parameter int                   TAG_WIDTH    = DEF_TAG_WIDTH,
  parameter logic [TAG_WIDTH-1:0] INVALID_TAG  = DEF_INVALID_TAG,
  parameter logic [TAG_WIDTH-1:0] DATA_TAG0    = DEF_DATA_TAG0,
  parameter logic [TAG_WIDTH-1:0] DATA_TAG1    = DEF_DATA_TAG1,
  parameter logic [TAG_WIDTH-1:0] DATA_END_TAG = DEF_DATA_END_TAG,
  parameter int                   OPE_WIDTH    = 3,
  parameter int                   PIX_WIDTH    = 8,
  parameter int                   DATA_WIDTH   = PIX_WIDTH + TAG_WIDTH,
  parameter int                   RECIP_SHIFT  = 16,
  parameter int unsigned          BOX_RECIP    = box_recip(OPE_WIDTH, RECIP_SHIFT),
  parameter int                   CNT_WIDTH    = 24
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    reflesh,
  input  logic [DATA_WIDTH*OPE_WIDTH*OPE_WIDTH-1:0] data_bus,
  input  logic [1:0]                              mode_in,
  input  logic [PIX_WIDTH-1:0]                    thr_in,
  output logic [DATA_WIDTH-1:0]                   out,
  output logic                                    frame_done,
  output logic [CNT_WIDTH-1:0]                    pix_count
);

  localparam int c_n      = OPE_WIDTH * OPE_WIDTH;
  localparam int c_sum_w  = PIX_WIDTH + $clog2(c_n);
  localparam int c_ctr    = (OPE_WIDTH / 2) * OPE_WIDTH + (OPE_WIDTH / 2);
  localparam int c_prod_w = c_sum_w + RECIP_SHIFT;
  localparam logic [c_prod_w-1:0] c_recip = c_prod_w'(BOX_RECIP);

  logic [PIX_WIDTH-1:0] w_pix     [c_n];
  logic [c_sum_w-1:0]   w_pix_ext [c_n];
  logic [c_sum_w-1:0]   w_top_acc   [OPE_WIDTH+1];
  logic [c_sum_w-1:0]   w_bot_acc   [OPE_WIDTH+1];
  logic [c_sum_w-1:0]   w_left_acc  [OPE_WIDTH+1];
  logic [c_sum_w-1:0]   w_right_acc [OPE_WIDTH+1];
  logic [c_sum_w-1:0]   w_tot_acc   [c_n+1];
  logic [TAG_WIDTH-1:0] w_tag_in;

  for (genvar i = 0; i < c_n; i++) begin : g_unpack
    assign w_pix[i]     = data_bus[i*DATA_WIDTH +: PIX_WIDTH];
    assign w_pix_ext[i] = {{(c_sum_w-PIX_WIDTH){1'b0}}, w_pix[i]};
    assign w_tot_acc[i+1] = w_tot_acc[i] + w_pix_ext[i];
  end
  assign w_tot_acc[0] = '0;

  for (genvar k = 0; k < OPE_WIDTH; k++) begin : g_edge_sums
    assign w_top_acc[k+1]   = w_top_acc[k]   + w_pix_ext[k];
    assign w_bot_acc[k+1]   = w_bot_acc[k]   + w_pix_ext[(OPE_WIDTH-1)*OPE_WIDTH + k];
    assign w_left_acc[k+1]  = w_left_acc[k]  + w_pix_ext[k*OPE_WIDTH];
    assign w_right_acc[k+1] = w_right_acc[k] + w_pix_ext[k*OPE_WIDTH + OPE_WIDTH - 1];
  end
  assign w_top_acc[0]   = '0;
  assign w_bot_acc[0]   = '0;
  assign w_left_acc[0]  = '0;
  assign w_right_acc[0] = '0;

  assign w_tag_in = data_bus[c_ctr*DATA_WIDTH + PIX_WIDTH +: TAG_WIDTH];

  // Mode/threshold shadows: loaded once after reset and at every frame end
  mode_e                r_mode_sh;
  logic [PIX_WIDTH-1:0] r_thr_sh;
  logic                 r_first;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode_sh <= MODE_PASS;
      r_thr_sh  <= '0;
      r_first   <= 1'b1;
    end else begin
      r_first <= 1'b0;
      if (r_first || (!reflesh && w_tag_in == DATA_END_TAG)) begin
        r_mode_sh <= mode_e'(mode_in);
        r_thr_sh  <= thr_in;
      end
    end
  end

  // Stage 1 / stage 2 registers
  logic [c_sum_w-1:0]   r_s1_top, r_s1_bot, r_s1_left, r_s1_right, r_s1_sum;
  logic [PIX_WIDTH-1:0] r_s1_pix, r_s1_thr, r_s2_pix, r_s2_thr, r_s2_avg;
  logic [TAG_WIDTH-1:0] r_s1_tag, r_s2_tag;
  mode_e                r_s1_mode, r_s2_mode;
  logic [c_sum_w-1:0]   w_gx, w_gy;
  logic [CNT_WIDTH-1:0] r_run;

  abs_diff #(.W(c_sum_w)) u_gx (
    .clk (clk), .rst (rst), .clr (reflesh),
    .a   (r_s1_right), .b (r_s1_left), .y (w_gx)
  );

  abs_diff #(.W(c_sum_w)) u_gy (
    .clk (clk), .rst (rst), .clr (reflesh),
    .a   (r_s1_bot), .b (r_s1_top), .y (w_gy)
  );

  logic [c_prod_w-1:0]  w_prod;
  logic [PIX_WIDTH-1:0] w_avg;
  logic [c_sum_w:0]     w_edge;
  logic [PIX_WIDTH-1:0] w_res;
  logic [PIX_WIDTH-1:0] w_pix_out;
  logic                 w_unused;

  assign w_prod   = {{RECIP_SHIFT{1'b0}}, r_s1_sum} * c_recip;
  assign w_unused = ^{w_prod[RECIP_SHIFT-1:0], INVALID_TAG, DATA_TAG1};

  always_comb begin
    w_avg = w_prod[RECIP_SHIFT +: PIX_WIDTH];
    if (|w_prod[c_prod_w-1:RECIP_SHIFT+PIX_WIDTH]) begin
      w_avg = '1;
    end
  end

  always_comb begin
    w_edge    = {1'b0, w_gx} + {1'b0, w_gy};
    w_res     = r_s2_pix;
    w_pix_out = '1;
    case (r_s2_mode)
      MODE_PASS: w_res = r_s2_pix;
      MODE_BOX:  w_res = r_s2_avg;
      MODE_EDGE: w_res = (|w_edge[c_sum_w:PIX_WIDTH]) ? '1 : w_edge[PIX_WIDTH-1:0];
      MODE_THR:  w_res = (r_s2_pix >= r_s2_thr) ? '1 : '0;
    endcase
    if (r_s2_tag == DATA_TAG0) begin
      w_pix_out = w_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || reflesh) begin
      r_s1_top   <= '0;
      r_s1_bot   <= '0;
      r_s1_left  <= '0;
      r_s1_right <= '0;
      r_s1_sum   <= '0;
      r_s1_pix   <= '0;
      r_s1_thr   <= '0;
      r_s1_tag   <= '0;
      r_s1_mode  <= MODE_PASS;
      r_s2_pix   <= '0;
      r_s2_thr   <= '0;
      r_s2_avg   <= '0;
      r_s2_tag   <= '0;
      r_s2_mode  <= MODE_PASS;
      out        <= '0;
      frame_done <= 1'b0;
      r_run      <= '0;
    end else begin
      r_s1_top   <= w_top_acc[OPE_WIDTH];
      r_s1_bot   <= w_bot_acc[OPE_WIDTH];
      r_s1_left  <= w_left_acc[OPE_WIDTH];
      r_s1_right <= w_right_acc[OPE_WIDTH];
      r_s1_sum   <= w_tot_acc[c_n];
      r_s1_pix   <= w_pix[c_ctr];
      r_s1_thr   <= r_thr_sh;
      r_s1_tag   <= w_tag_in;
      r_s1_mode  <= r_mode_sh;

      r_s2_pix   <= r_s1_pix;
      r_s2_thr   <= r_s1_thr;
      r_s2_avg   <= w_avg;
      r_s2_tag   <= r_s1_tag;
      r_s2_mode  <= r_s1_mode;

      out        <= {r_s2_tag, w_pix_out};
      frame_done <= (r_s2_tag == DATA_END_TAG);
      if (r_s2_tag == DATA_END_TAG) begin
        r_run <= '0;
      end else if (r_s2_tag == DATA_TAG0 && r_run != '1) begin
        r_run <= r_run + 1'b1;
      end
    end
  end

  // Last completed frame's count survives a flush
  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_count <= '0;
    end else if (!reflesh && r_s2_tag == DATA_END_TAG) begin
      pix_count <= r_run;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_filter_operation_pipe.sv
// +------------------------------------------------------------------+
// | tb_filter_operation_pipe: directed vectors and frame sequences    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_filter_operation_pipe;

  localparam int DW = 10;
  localparam int NB = DW * 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          reflesh = 1'b0;
  logic [NB-1:0] data_bus = '0;
  logic [1:0]    mode_in = 2'd0;
  logic [7:0]    thr_in = 8'd0;
  logic [9:0]    out;
  logic          frame_done;
  logic [23:0]   pix_count;

  int n_cmp = 0;
  int n_bad = 0;

  filter_operation_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .reflesh    (reflesh),
    .data_bus   (data_bus),
    .mode_in    (mode_in),
    .thr_in     (thr_in),
    .out        (out),
    .frame_done (frame_done),
    .pix_count  (pix_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Window whose columns (or rows) carry values a,b,c; every element tagged
  function automatic logic [NB-1:0] win(input logic [1:0] tag, input bit rows,
                                        input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
    logic [NB-1:0] w;
    logic [7:0]    p;
    w = '0;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 3; x++) begin
        int sel;
        sel = rows ? y : x;
        p = (sel == 0) ? a : (sel == 1) ? b : c;
        w[(y*3+x)*DW +: DW] = {tag, p};
      end
    end
    return w;
  endfunction

  typedef struct {
    logic [1:0] tag;
    logic [1:0] mode;
    logic [7:0] thr;
    bit         rows;
    logic [7:0] a, b, c;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[15];

  logic [NB-1:0] fin   [11];
  logic [1:0]    fmode [11];
  logic [9:0]    fexp  [11];
  bit            ffd   [11];
  int            fpc   [11];

  initial begin
    logic [1:0] cur_mode;
    logic [7:0] cur_thr;
    bit         found;

    tbl[0]  = '{2'd1, 2'd0, 8'd0,   1'b0, 8'd10,  8'd77,  8'd50,  {2'd1, 8'd77}};
    tbl[1]  = '{2'd2, 2'd0, 8'd0,   1'b0, 8'd10,  8'd77,  8'd50,  {2'd2, 8'hFF}};
    tbl[2]  = '{2'd0, 2'd0, 8'd0,   1'b0, 8'd10,  8'd77,  8'd50,  {2'd0, 8'hFF}};
    tbl[3]  = '{2'd1, 2'd1, 8'd0,   1'b0, 8'd90,  8'd90,  8'd90,  {2'd1, 8'd90}};
    tbl[4]  = '{2'd1, 2'd1, 8'd0,   1'b0, 8'd0,   8'd0,   8'd9,   {2'd1, 8'd3}};
    tbl[5]  = '{2'd1, 2'd1, 8'd0,   1'b0, 8'd255, 8'd255, 8'd255, {2'd1, 8'd255}};
    tbl[6]  = '{2'd1, 2'd2, 8'd0,   1'b0, 8'd10,  8'd30,  8'd50,  {2'd1, 8'd120}};
    tbl[7]  = '{2'd1, 2'd2, 8'd0,   1'b0, 8'd0,   8'd0,   8'd255, {2'd1, 8'd255}};
    tbl[8]  = '{2'd1, 2'd2, 8'd0,   1'b1, 8'd0,   8'd0,   8'd20,  {2'd1, 8'd60}};
    tbl[9]  = '{2'd1, 2'd2, 8'd0,   1'b0, 8'd40,  8'd40,  8'd40,  {2'd1, 8'd0}};
    tbl[10] = '{2'd1, 2'd3, 8'd100, 1'b0, 8'd0,   8'd100, 8'd0,   {2'd1, 8'hFF}};
    tbl[11] = '{2'd1, 2'd3, 8'd100, 1'b0, 8'd0,   8'd99,  8'd0,   {2'd1, 8'h00}};
    tbl[12] = '{2'd2, 2'd3, 8'd100, 1'b0, 8'd0,   8'd99,  8'd0,   {2'd2, 8'hFF}};
    tbl[13] = '{2'd1, 2'd3, 8'd0,   1'b0, 8'd0,   8'd0,   8'd0,   {2'd1, 8'hFF}};
    tbl[14] = '{2'd1, 2'd3, 8'd255, 1'b0, 8'd0,   8'd254, 8'd0,   {2'd1, 8'h00}};

    // Reset: two cycles low with an all-INVALID window
    step;
    check("rst_out", out, 10'h000);
    check("rst_fd", frame_done, 1'b0);
    check("rst_cnt", pix_count, 24'd0);
    step;
    rst = 1'b1;
    step; step; step;
    check("post_rst_out", out, {2'd0, 8'hFF});
    check("post_rst_fd", frame_done, 1'b0);
    check("post_rst_cnt", pix_count, 24'd0);

    // Vector table; an END cycle latches a new mode/threshold when needed
    cur_mode = 2'd0;
    cur_thr  = 8'd0;
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].mode != cur_mode || tbl[i].thr != cur_thr) begin
        mode_in  = tbl[i].mode;
        thr_in   = tbl[i].thr;
        data_bus = win(2'd3, 1'b0, 8'd0, 8'd0, 8'd0);
        step;
        cur_mode = tbl[i].mode;
        cur_thr  = tbl[i].thr;
      end
      data_bus = win(tbl[i].tag, tbl[i].rows, tbl[i].a, tbl[i].b, tbl[i].c);
      step; step; step;
      check($sformatf("vec%0d", i), out, tbl[i].exp);
    end

    // Exact 3-cycle latency (mode 3, thr 255, centre 255)
    data_bus = '0;
    step; step; step;
    data_bus = win(2'd1, 1'b0, 8'd0, 8'd255, 8'd0);
    step;
    data_bus = '0;
    step;
    check("lat_early", out, {2'd0, 8'hFF});
    step;
    check("lat_exact", out, {2'd1, 8'hFF});
    step;
    check("lat_after", out, {2'd0, 8'hFF});

    // Frame of 5, mid-frame mode change, then back-to-back END tags
    thr_in = 8'd0;
    fin[0] = win(2'd3, 1'b0, 8'd0, 8'd0, 8'd0);    fmode[0] = 2'd1;
    fexp[0] = {2'd3, 8'hFF}; ffd[0] = 1'b1; fpc[0] = -1;
    for (int k = 1; k <= 5; k++) begin
      fin[k] = win(2'd1, 1'b0, 8'd10, 8'd30, 8'd50);
      fmode[k] = (k == 1) ? 2'd1 : 2'd2;
      fexp[k] = {2'd1, 8'd30}; ffd[k] = 1'b0; fpc[k] = -1;
    end
    fin[6] = win(2'd3, 1'b0, 8'd0, 8'd0, 8'd0);    fmode[6] = 2'd2;
    fexp[6] = {2'd3, 8'hFF}; ffd[6] = 1'b1; fpc[6] = 5;
    fin[7] = win(2'd1, 1'b0, 8'd10, 8'd30, 8'd50); fmode[7] = 2'd2;
    fexp[7] = {2'd1, 8'd120}; ffd[7] = 1'b0; fpc[7] = -1;
    fin[8] = win(2'd3, 1'b0, 8'd0, 8'd0, 8'd0);    fmode[8] = 2'd2;
    fexp[8] = {2'd3, 8'hFF}; ffd[8] = 1'b1; fpc[8] = 1;
    fin[9] = win(2'd3, 1'b0, 8'd0, 8'd0, 8'd0);    fmode[9] = 2'd2;
    fexp[9] = {2'd3, 8'hFF}; ffd[9] = 1'b1; fpc[9] = 0;
    fin[10] = '0;                                   fmode[10] = 2'd2;
    fexp[10] = {2'd0, 8'hFF}; ffd[10] = 1'b0; fpc[10] = -1;

    for (int s = 0; s < 13; s++) begin
      if (s < 11) begin
        data_bus = fin[s];
        mode_in  = fmode[s];
      end else begin
        data_bus = '0;
      end
      step;
      if (s >= 2) begin
        check($sformatf("frm_out%0d", s - 2), out, fexp[s-2]);
        check($sformatf("frm_fd%0d", s - 2), frame_done, ffd[s-2]);
        if (fpc[s-2] >= 0) begin
          check($sformatf("frm_cnt%0d", s - 2), pix_count, fpc[s-2]);
        end
      end
    end

    // Flush mid-frame: in-flight pixels dropped, pix_count held
    data_bus = win(2'd3, 1'b0, 8'd0, 8'd0, 8'd0); step;
    data_bus = win(2'd1, 1'b0, 8'd10, 8'd30, 8'd50); step; step;
    data_bus = win(2'd3, 1'b0, 8'd0, 8'd0, 8'd0); step;
    data_bus = win(2'd1, 1'b0, 8'd10, 8'd30, 8'd50); step; step; step;
    reflesh = 1'b1;
    step;
    reflesh = 1'b0;
    data_bus = '0;
    check("rf_out", out, 10'h000);
    check("rf_fd", frame_done, 1'b0);
    check("rf_cnt_hold", pix_count, 24'd2);
    for (int k = 0; k < 3; k++) begin
      step;
      check($sformatf("rf_nofd%0d", k), frame_done, 1'b0);
    end
    data_bus = win(2'd1, 1'b0, 8'd10, 8'd30, 8'd50);
    step; step; step; step;
    data_bus = win(2'd3, 1'b0, 8'd0, 8'd0, 8'd0);
    step;
    data_bus = '0;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      step;
      if (frame_done === 1'b1) begin
        found = 1'b1;
        check("rf_frame_cnt", pix_count, 24'd4);
        check("rf_frame_tag", out[9:8], 2'd3);
        check("rf_frame_lat", k, 1);
      end
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rf_frame_done: no pulse within 8 cycles, required 1");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
